gray_to_rgb_stream: RTL
=======================

GRAY_TO_RGB_STREAM -- requirements
Module: gray_to_rgb_stream

Interface
REQ-001 SHALL have parameter PIX_W, default 8: input pixel width, 1..16.
REQ-002 SHALL have parameter CH_W, default 8: output width per colour channel, 1..16.
REQ-003 SHALL have parameters IMG_W and IMG_H, defaults 640 and 480: frame width and height in pixels, each at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_pixel, input, PIX_W bits: grey or binary source pixel.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the input handshake.
REQ-008 SHALL have port mode, input, 2 bits: 00 grey replicate, 01 threshold, 10 inverted grey, 11 false colour.
REQ-009 SHALL have port threshold, input, PIX_W bits: comparison level for mode 01.
REQ-010 SHALL have ports fg_rgb and bg_rgb, input, 3*CH_W bits each: mode 01 colours, packed {R,G,B}.
REQ-011 SHALL have ports out_r, out_g and out_b, output, CH_W bits each: the RGB result.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the output handshake.
REQ-013 SHALL have ports out_sof, out_eol and out_eof, output, 1 bit each: start-of-frame, end-of-line and end-of-frame flags, qualified by out_valid.

Function
REQ-014 SHALL accept an input pixel only on a cycle where in_valid=1 and in_ready=1.
REQ-015 SHALL transfer an output pixel only on a cycle where out_valid=1 and out_ready=1.
REQ-016 SHALL use a 2-stage register pipeline: stage 1 captures the pixel, mode, threshold, colours and flags; stage 2 holds the computed RGB.
REQ-017 SHALL have a latency of 2 cycles from input acceptance to out_valid when out_ready is held at 1.
REQ-018 SHALL sustain one pixel per cycle when out_ready is held at 1.
REQ-019 SHALL advance each stage when it is empty or when its downstream accepts in that cycle.
REQ-020 SHALL drive in_ready = !s1_valid || s1_advance, combinationally, with no dependency on in_valid.
REQ-021 SHALL hold out_r, out_g, out_b, out_valid and all flags stable while out_valid=1 and out_ready=0.
REQ-022 SHALL lose and duplicate no pixel under any pattern of stalls on either side.
REQ-023 SHALL sample mode, threshold, fg_rgb and bg_rgb at input acceptance and keep them attached to that pixel, so that mid-stream changes affect only pixels accepted afterwards.
REQ-024 SHALL scale a grey value g to a CH_W-bit value c as follows: if CH_W >= PIX_W, g is MSB-aligned and the low bits are filled by repeating g; otherwise c is the top CH_W bits of g.
REQ-025 SHALL implement mode 00 as R=G=B=c(g).
REQ-026 SHALL implement mode 10 as R=G=B=c(~g).
REQ-027 SHALL implement mode 01 as RGB=fg_rgb when g >= threshold, and RGB=bg_rgb otherwise (unsigned compare).
REQ-028 SHALL implement mode 11 with t = top 2 bits of c(g): t=0 gives {0,0,c}, t=1 gives {0,c,max}, t=2 gives {c,max,~c}, t=3 gives {max,~c,0}, where max is all ones.
REQ-029 SHALL keep column counter x in 0..IMG_W-1 and row counter y in 0..IMG_H-1, advancing only on input acceptance.
REQ-030 SHALL, when x=IMG_W-1, wrap x to 0 and increment y.
REQ-031 SHALL, when x=IMG_W-1 and y=IMG_H-1, wrap both x and y to 0.
REQ-032 SHALL compute flags at acceptance and carry them through the pipeline with the pixel: sof at (0,0), eol at x=IMG_W-1, eof at (IMG_W-1, IMG_H-1).

Reset
REQ-033 SHALL, while rst=1 at a clock edge, clear both stage valid bits, x, y and all output data and flags to 0.
REQ-034 SHALL drive out_valid=0 during and immediately after reset.
REQ-035 SHALL drive in_ready=1 in the first cycle after reset.
REQ-036 SHALL discard in-flight pixels on reset mid-frame, with the next accepted pixel carrying sof=1.

Configuration
REQ-037 SHALL, with macro GRAY_TO_RGB_FRAME_SUM_EN defined, add output frame_sum (32 bits) and output frame_sum_valid (1 bit, one-cycle pulse).
REQ-038 SHALL, with GRAY_TO_RGB_FRAME_SUM_EN defined, accumulate the modulo-2^32 sum of R+G+B over every output transfer.
REQ-039 SHALL, with GRAY_TO_RGB_FRAME_SUM_EN defined, on the output transfer of the eof pixel load frame_sum with the accumulator plus that pixel's R+G+B, pulse frame_sum_valid the next cycle, and clear the accumulator.
REQ-040 SHALL reset frame_sum and the accumulator to 0 with rst.
REQ-041 SHALL, without GRAY_TO_RGB_FRAME_SUM_EN, have neither port nor any sum logic, and behave otherwise identically.

Verification
REQ-042 SHALL cover: defaults, mode 00, out_ready=1, in_pixel=0xA5 -> out_r=out_g=out_b=0xA5 exactly 2 cycles after acceptance.
REQ-043 SHALL cover: mode 01, threshold=0x80, fg=0xFF0000, bg=0x0000FF, pixels 0x7F then 0x80 -> RGB 0x0000FF then 0xFF0000.
REQ-044 SHALL cover: PIX_W=1, CH_W=8, mode 10, pixels 1 then 0 -> 0x00 then 0xFF on all channels.
REQ-045 SHALL cover: IMG_W=4, IMG_H=2, 8 pixels -> sof on pixel 0 only, eol on pixels 3 and 7, eof on pixel 7, and the 9th pixel carrying sof again.
REQ-046 SHALL cover: random in_valid and out_ready, 1000 pixels -> output sequence equals the reference model, with outputs held stable during every stall.
REQ-047 SHALL cover: rst asserted after 3 of 8 pixels -> out_valid=0 next cycle and the next accepted pixel carrying sof; with GRAY_TO_RGB_FRAME_SUM_EN, mode 00 over an all-0x01 4x2 frame -> frame_sum=24.

Source files
------------

// File: rtl/gray_to_rgb_stream.sv
// gray_to_rgb_stream
//   Streaming grey/binary to RGB converter with a 2-stage valid/ready
//   pipeline and frame position flags.
//   Stage 1 captures the pixel with its mode, threshold, colours and flags.
//   Stage 2 holds the computed RGB result.
//
// Parameters
//   PIX_W        input pixel width (1..16)
//   CH_W         output width per colour channel (1..16)
//   IMG_W/IMG_H  frame size in pixels (each >= 2)
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_pixel/in_valid/in_ready        input stream
//   mode                   00 grey, 01 threshold, 10 inverted grey, 11 false colour
//   threshold              mode 01 comparison level
//   fg_rgb, bg_rgb         mode 01 colours, packed {R,G,B}
//   out_r/out_g/out_b/out_valid/out_ready   output stream
//   out_sof/out_eol/out_eof  frame flags, qualified by out_valid
//
// Optional feature (macro GRAY_TO_RGB_FRAME_SUM_EN)
//   frame_sum              modulo-2^32 sum of R+G+B over the last frame
//   frame_sum_valid        one-cycle pulse after the eof pixel transfers
module gray_to_rgb_stream #(
  parameter int PIX_W = 8,
  parameter int CH_W  = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PIX_W-1:0]    in_pixel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          mode,
  input  logic [PIX_W-1:0]    threshold,
  input  logic [3*CH_W-1:0]   fg_rgb,
  input  logic [3*CH_W-1:0]   bg_rgb,
  output logic [CH_W-1:0]     out_r,
  output logic [CH_W-1:0]     out_g,
  output logic [CH_W-1:0]     out_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_sof,
  output logic                out_eol,
  output logic                out_eof
`ifdef GRAY_TO_RGB_FRAME_SUM_EN
  ,
  output logic [31:0]         frame_sum,
  output logic                frame_sum_valid
`endif
);

  typedef enum logic [1:0] {
    MODE_GREY   = 2'b00,
    MODE_THRESH = 2'b01,
    MODE_INV    = 2'b10,
    MODE_FALSE  = 2'b11
  } mode_e;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // MSB-aligned repetition of g; when CH_W < PIX_W this reduces to the top
  // CH_W bits of g.
  function automatic logic [CH_W-1:0] f_scale(input logic [PIX_W-1:0] g);
    logic [CH_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < CH_W; i++) begin
      c[CH_W-1-i] = g[PIX_W-1-(i % PIX_W)];
    end
    return c;
  endfunction

  // Top two bits of f_scale(g), built by the same repetition rule so that a
  // 1-bit channel still yields a defined 2-bit band index.
  function automatic logic [1:0] f_band(input logic [PIX_W-1:0] g);
    logic [1:0] t;
    t = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      t[1-i] = g[PIX_W-1-(i % PIX_W)];
    end
    return t;
  endfunction

  // Frame position
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_last;
  logic          w_y_last;

  // Stage 1
  logic              r_s1_valid;
  logic [PIX_W-1:0]  r_s1_pix;
  logic [PIX_W-1:0]  r_s1_thr;
  mode_e             r_s1_mode;
  logic [3*CH_W-1:0] r_s1_fg;
  logic [3*CH_W-1:0] r_s1_bg;
  logic              r_s1_sof;
  logic              r_s1_eol;
  logic              r_s1_eof;

  // Stage 2
  logic              r_s2_valid;
  logic [CH_W-1:0]   r_s2_r;
  logic [CH_W-1:0]   r_s2_g;
  logic [CH_W-1:0]   r_s2_b;
  logic              r_s2_sof;
  logic              r_s2_eol;
  logic              r_s2_eof;

  logic              w_s2_adv;
  logic              w_accept;
  logic [CH_W-1:0]   w_c;
  logic [CH_W-1:0]   w_ci;
  logic [1:0]        w_t;
  logic [CH_W-1:0]   w_r;
  logic [CH_W-1:0]   w_g;
  logic [CH_W-1:0]   w_b;

  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);

  // Stage 2 takes new data when empty or when its content leaves this cycle;
  // stage 1 can then refill whenever it is empty or moving into stage 2.
  assign w_s2_adv = !r_s2_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_accept = in_valid && in_ready;

  assign w_c  = f_scale(r_s1_pix);
  assign w_ci = f_scale(~r_s1_pix);
  assign w_t  = f_band(r_s1_pix);

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (r_s1_mode)
      MODE_GREY: begin
        w_r = w_c;
        w_g = w_c;
        w_b = w_c;
      end
      MODE_INV: begin
        w_r = w_ci;
        w_g = w_ci;
        w_b = w_ci;
      end
      MODE_THRESH: begin
        if (r_s1_pix >= r_s1_thr) begin
          {w_r, w_g, w_b} = r_s1_fg;
        end else begin
          {w_r, w_g, w_b} = r_s1_bg;
        end
      end
      MODE_FALSE: begin
        case (w_t)
          2'd0: w_b = w_c;
          2'd1: begin
            w_g = w_c;
            w_b = '1;
          end
          2'd2: begin
            w_r = w_c;
            w_g = '1;
            w_b = ~w_c;
          end
          default: begin
            w_r = '1;
            w_g = ~w_c;
          end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : r_y + YW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_thr   <= '0;
      r_s1_mode  <= MODE_GREY;
      r_s1_fg    <= '0;
      r_s1_bg    <= '0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_eof   <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_pix  <= in_pixel;
        r_s1_thr  <= threshold;
        r_s1_mode <= mode_e'(mode);
        r_s1_fg   <= fg_rgb;
        r_s1_bg   <= bg_rgb;
        r_s1_sof  <= (r_x == '0) && (r_y == '0);
        r_s1_eol  <= w_x_last;
        r_s1_eof  <= w_x_last && w_y_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_r     <= '0;
      r_s2_g     <= '0;
      r_s2_b     <= '0;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
      r_s2_eof   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_r   <= w_r;
        r_s2_g   <= w_g;
        r_s2_b   <= w_b;
        r_s2_sof <= r_s1_sof;
        r_s2_eol <= r_s1_eol;
        r_s2_eof <= r_s1_eof;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_r     = r_s2_r;
  assign out_g     = r_s2_g;
  assign out_b     = r_s2_b;
  assign out_sof   = r_s2_sof;
  assign out_eol   = r_s2_eol;
  assign out_eof   = r_s2_eof;

`ifdef GRAY_TO_RGB_FRAME_SUM_EN
  logic [31:0] r_acc;
  logic [31:0] r_frame_sum;
  logic        r_frame_sum_valid;
  logic [31:0] w_pix_sum;

  assign w_pix_sum = 32'(r_s2_r) + 32'(r_s2_g) + 32'(r_s2_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc             <= '0;
      r_frame_sum       <= '0;
      r_frame_sum_valid <= 1'b0;
    end else begin
      r_frame_sum_valid <= 1'b0;
      if (r_s2_valid && out_ready) begin
        if (r_s2_eof) begin
          r_frame_sum       <= r_acc + w_pix_sum;
          r_frame_sum_valid <= 1'b1;
          r_acc             <= '0;
        end else begin
          r_acc <= r_acc + w_pix_sum;
        end
      end
    end
  end

  assign frame_sum       = r_frame_sum;
  assign frame_sum_valid = r_frame_sum_valid;
`endif

endmodule
